conv_s2_frame_ctrl: RTL and testbench
=====================================

Name: conv_s2_frame_ctrl

Overview:
- Frame sequencer for the 3x3, stride-2, padding-0 convolution datapath (3 input channels, 32 output channels, merged output stream).
- Accepts one D x D frame of 3-channel pixels after a start pulse and forwards it, registered, to the convolution input.
- Tracks input row/column and flags the stride-2 window anchor positions.
- Counts merged outputs until the expected ((D-3)/2+1)^2 results arrive or a drain timeout expires, then pulses done.

Parameters:
D, 220, input frame width = height in pixels (D >= 3)
DATA_WIDTH, 32, pixel word width
CW, 16, width of row/col/output counters
TMO, 4096, max idle cycles in DRAIN between merged outputs before timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
start  in  1  one-cycle frame start request
valid_in  in  1  input pixel valid, all 3 channels together
pxl_in_1  in  DATA_WIDTH  channel-1 input pixel
pxl_in_2  in  DATA_WIDTH  channel-2 input pixel
pxl_in_3  in  DATA_WIDTH  channel-3 input pixel
ready_in  out  1  controller accepts pixels (high only in RUN)
pxl_out_1..3  out  DATA_WIDTH each  registered pixels to the convolution inputs
valid_out_1..3  out  1 each  registered valid to the convolution inputs (identical copies)
win_valid  out  1  current forwarded pixel completes a stride-2 window
conv_valid  in  1  merged convolution output valid
out_count  out  CW  merged outputs counted this frame
busy  out  1  state != IDLE
done  out  1  one-cycle end-of-frame pulse
err_overrun  out  1  sticky: valid_in seen while ready_in=0
err_timeout  out  1  sticky: drain timeout occurred

Behaviour:
- Reset: reset=0 at a clk edge forces IDLE.
  - All outputs go to 0; col, row, out_count and the timeout counter clear; sticky errors clear.
  - This applies from any state, mid-frame included; partial frame data is abandoned and no done pulse is issued.
- Constants: OUT_SIDE = (D-3)/2 + 1 (integer division); OUT_TOTAL = OUT_SIDE * OUT_SIDE; PIX_TOTAL = D*D.
- States:
  - IDLE: ready_in=0. start=1 -> RUN; clear col, row and out_count.
  - RUN: ready_in=1. Each accepted pixel (valid_in=1) advances col 0..D-1; wrap to 0 increments row. Acceptance of pixel (row=D-1, col=D-1) -> DRAIN. start is ignored.
  - DRAIN: ready_in=0. When out_count reaches OUT_TOTAL -> DONE. A timeout counter clears on each conv_valid and increments otherwise; reaching TMO sets err_timeout -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. out_count holds until the next start.
- Forwarding:
  - pxl_out_k <= pxl_in_k and valid_out_k <= valid_in & ready_in, one cycle latency.
  - When not valid, pxl_out_k holds its last value.
- win_valid:
  - Registered alongside valid_out_1, high only with it.
  - Condition on the accepted pixel's counters: row >= 2, col >= 2, row even, col even.
  - For even D, the last row/column never anchors a window.
- out_count:
  - Increments on conv_valid in RUN and DRAIN; saturates at OUT_TOTAL.
  - conv_valid in IDLE or DONE is ignored.
- Boundary cases:
  - valid_in while ready_in=0: pixel dropped, err_overrun set (sticky until reset).
  - start coinciding with the final pixel: ignored.
  - conv_valid in the same cycle as the final RUN pixel: counted.
  - The DRAIN exit check uses the incremented value, so the last conv_valid reaches DONE on the next cycle.
- Width rule: CW must hold PIX_TOTAL-1 and OUT_TOTAL (D=220: OUT_TOTAL=11881 fits in 16 bits).

Test Plan:
- D=7, reset low 2 cycles, start, 49 consecutive valid pixels (value = index) -> valid_out_1..3 each high 49 cycles, delayed 1 cycle; pxl_out_1 follows index sequence; win_valid high exactly 9 times, at indices 16,18,20,30,32,34,44,46,48; state DRAIN after index 48.
- Same frame, then 9 conv_valid pulses spaced 3 cycles -> out_count=9; done one cycle high the cycle after DRAIN sees count 9; busy falls with IDLE.
- D=7, valid_in toggling every other cycle -> win_valid positions unchanged by gaps; 49 pixels still accepted.
- Drive valid_in in IDLE before start -> err_overrun=1, valid_out_1 stays 0; remains 1 through a full frame until reset low.
- D=7, TMO=16, only 5 conv_valid in DRAIN -> err_timeout=1 16 cycles after the 5th; done pulses; out_count=5.
- Reset low at pixel 20 of RUN -> next cycle all outputs 0, state IDLE; new start then a full frame completes normally with 9 windows.

Source files
------------

// File: rtl/conv_s2_frame_ctrl.sv
// Frame sequencer for the 3x3 stride-2 convolution: accepts one DxD frame,
// forwards it registered, flags window anchors and counts merged outputs.
module conv_s2_frame_ctrl #(
  parameter int D          = 220,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 16,
  parameter int TMO        = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in_1,
  input  logic [DATA_WIDTH-1:0] pxl_in_2,
  input  logic [DATA_WIDTH-1:0] pxl_in_3,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] pxl_out_1,
  output logic [DATA_WIDTH-1:0] pxl_out_2,
  output logic [DATA_WIDTH-1:0] pxl_out_3,
  output logic                  valid_out_1,
  output logic                  valid_out_2,
  output logic                  valid_out_3,
  output logic                  win_valid,
  input  logic                  conv_valid,
  output logic [CW-1:0]         out_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overrun,
  output logic                  err_timeout
);
  localparam int OUT_SIDE  = (D - 3) / 2 + 1;
  localparam int OUT_TOTAL = OUT_SIDE * OUT_SIDE;
  localparam int TW        = $clog2(TMO + 1);
  localparam logic [CW-1:0] LAST  = CW'(D - 1);
  localparam logic [CW-1:0] OUT_T = CW'(OUT_TOTAL);
  localparam logic [TW-1:0] TMO_T = TW'(TMO);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d, row_q, row_d, cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic                  vld_q, vld_d, win_q, win_d;
  logic                  ovr_q, ovr_d, tmo_err_q, tmo_err_d;
  logic                  accept;

  assign ready_in = (state_q == RUN);
  assign accept   = valid_in & ready_in;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    p3_d      = p3_q;
    tmo_err_d = tmo_err_q;
    vld_d     = accept;
    // anchor = bottom-right corner of a stride-2 window, judged on pre-advance counters
    win_d     = accept && (row_q >= CW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
    ovr_d     = ovr_q | (valid_in & ~ready_in);
    if (accept) begin
      p1_d = pxl_in_1;
      p2_d = pxl_in_2;
      p3_d = pxl_in_3;
    end
    if (conv_valid && (state_q == RUN || state_q == DRAIN) && cnt_q != OUT_T)
      cnt_d = cnt_q + CW'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        col_d   = '0;
        row_d   = '0;
        cnt_d   = '0;
        tmo_d   = '0;
      end
      RUN: if (accept) begin
        if (col_q == LAST) begin
          col_d = '0;
          row_d = row_q + CW'(1);
          if (row_q == LAST) state_d = DRAIN;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_d == OUT_T) begin
          state_d = DONE;
        end else begin
          tmo_d = conv_valid ? '0 : tmo_q + TW'(1);
          if (tmo_d == TMO_T) begin
            tmo_err_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      vld_q     <= 1'b0;
      win_q     <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p3_q      <= p3_d;
      vld_q     <= vld_d;
      win_q     <= win_d;
      ovr_q     <= ovr_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign pxl_out_1   = p1_q;
  assign pxl_out_2   = p2_q;
  assign pxl_out_3   = p3_q;
  assign valid_out_1 = vld_q;
  assign valid_out_2 = vld_q;
  assign valid_out_3 = vld_q;
  assign win_valid   = win_q;
  assign out_count   = cnt_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err_overrun = ovr_q;
  assign err_timeout = tmo_err_q;
endmodule

// File: tb/tb_conv_s2_frame_ctrl.sv
// Randomized bench for conv_s2_frame_ctrl with D=7, TMO=16; window anchors and
// output counts come from a frame-index model of the stride-2 geometry.
module tb_conv_s2_frame_ctrl;
  localparam int D = 7, DW = 32, CW = 16, TMO = 16;
  localparam int NPIX = D * D;
  localparam int OUT_TOTAL = ((D - 3) / 2 + 1) * ((D - 3) / 2 + 1);

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, valid_in = 1'b0, conv_valid = 1'b0;
  logic [DW-1:0] pxl_in_1 = '0, pxl_in_2 = '0, pxl_in_3 = '0;
  logic [DW-1:0] pxl_out_1, pxl_out_2, pxl_out_3;
  logic ready_in, valid_out_1, valid_out_2, valid_out_3, win_valid;
  logic busy, done, err_overrun, err_timeout;
  logic [CW-1:0] out_count;

  int nvec = 0, nerr = 0;
  logic [DW-1:0] e1 = '0, e2 = '0, e3 = '0;

  conv_s2_frame_ctrl #(.D(D), .DATA_WIDTH(DW), .CW(CW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .valid_in(valid_in),
    .pxl_in_1(pxl_in_1), .pxl_in_2(pxl_in_2), .pxl_in_3(pxl_in_3),
    .ready_in(ready_in), .pxl_out_1(pxl_out_1), .pxl_out_2(pxl_out_2), .pxl_out_3(pxl_out_3),
    .valid_out_1(valid_out_1), .valid_out_2(valid_out_2), .valid_out_3(valid_out_3),
    .win_valid(win_valid), .conv_valid(conv_valid), .out_count(out_count),
    .busy(busy), .done(done), .err_overrun(err_overrun), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  function automatic bit win_at(input int k);
    int r, c;
    r = k / D;
    c = k % D;
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input int ncyc);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; valid_in = 1'b0; conv_valid = 1'b0;
    repeat (ncyc) tick();
    e1 = '0; e2 = '0; e3 = '0;
    nvec++;
    if ({ready_in, busy, done, valid_out_1, valid_out_2, valid_out_3, win_valid} !== 7'b0) begin
      nerr++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {ready_in, busy, done, valid_out_1, valid_out_2, valid_out_3, win_valid});
    end
    nvec++;
    if ({out_count, err_overrun, err_timeout} !== '0 || {pxl_out_1, pxl_out_2, pxl_out_3} !== '0) begin
      nerr++;
      $display("FAIL reset_cnt: cnt=%0d ovr=%b tmo=%b p1=%h want all 0",
               out_count, err_overrun, err_timeout, pxl_out_1);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    tick();
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (ready_in !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL start: ready=%b busy=%b want 1 1", ready_in, busy);
    end
  endtask

  // mode 0: every cycle, 1: alternate cycles, 2: random gaps
  task automatic feed(input int mode, input int npix, input bit last_extra, output int wins);
    int k, cyc;
    bit v;
    k = 0; cyc = 0; wins = 0;
    while (k < npix) begin
      if (cyc > 4 * npix + 20) begin
        nvec++; nerr++;
        $display("FAIL feed_budget: accepted %0d want %0d", k, npix);
        break;
      end
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
      valid_in = v;
      pxl_in_1 = $urandom; pxl_in_2 = $urandom; pxl_in_3 = $urandom;
      start      = last_extra && v && (k == npix - 1);
      conv_valid = last_extra && v && (k == npix - 1);
      tick();
      cyc++;
      nvec++;
      if ({valid_out_1, valid_out_2, valid_out_3} !== {3{v}}) begin
        nerr++;
        $display("FAIL fwd_valid: idx=%0d got %b want %b", k,
                 {valid_out_1, valid_out_2, valid_out_3}, {3{v}});
      end
      if (v) begin
        e1 = pxl_in_1; e2 = pxl_in_2; e3 = pxl_in_3;
      end
      nvec++;
      if (pxl_out_1 !== e1 || pxl_out_2 !== e2 || pxl_out_3 !== e3) begin
        nerr++;
        $display("FAIL fwd_data: idx=%0d got %h %h %h want %h %h %h", k,
                 pxl_out_1, pxl_out_2, pxl_out_3, e1, e2, e3);
      end
      nvec++;
      if (win_valid !== (v && win_at(k))) begin
        nerr++;
        $display("FAIL win_valid: idx=%0d got %b want %b", k, win_valid, v && win_at(k));
      end
      if (win_valid === 1'b1) wins++;
      if (v) k++;
      if (v && k == NPIX) begin
        nvec++;
        if (ready_in !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
          nerr++;
          $display("FAIL drain_entry: ready=%b busy=%b done=%b want 0 1 0", ready_in, busy, done);
        end
      end
    end
    @(negedge clk);
    valid_in = 1'b0; start = 1'b0; conv_valid = 1'b0;
  endtask

  // n conv_valid pulses, each preceded by two idle cycles; returns just after the last
  task automatic drive_cv(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge clk);
      conv_valid = 1'b1;
      tick();
      nvec++;
      if (out_count !== CW'(base + i + 1)) begin
        nerr++;
        $display("FAIL out_count: got %0d want %0d", out_count, base + i + 1);
      end
      @(negedge clk);
      conv_valid = 1'b0;
    end
  endtask

  task automatic check_done_pulse(input string tag);
    nvec++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL %s_done: done=%b busy=%b want 1 1", tag, done, busy);
    end
    tick();
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_idle: done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_frame_done();
    int w;
    do_start();
    feed(0, NPIX, 1'b1, w);
    nvec++;
    if (w != 9) begin nerr++; $display("FAIL win_count: got %0d want 9", w); end
    nvec++;
    if (out_count !== CW'(1)) begin
      nerr++; $display("FAIL cv_last_pixel: got %0d want 1", out_count);
    end
    drive_cv(OUT_TOTAL - 1, 1);
    check_done_pulse("frame");
    nvec++;
    if (out_count !== CW'(OUT_TOTAL) || err_timeout !== 1'b0) begin
      nerr++;
      $display("FAIL count_hold: cnt=%0d tmo=%b want %0d 0", out_count, err_timeout, OUT_TOTAL);
    end
  endtask

  task automatic test_gaps(input int mode);
    int w;
    do_start();
    feed(mode, NPIX, 1'b0, w);
    nvec++;
    if (w != 9) begin nerr++; $display("FAIL gap_win_count: mode=%0d got %0d want 9", mode, w); end
    drive_cv(OUT_TOTAL, 0);
    check_done_pulse("gap");
  endtask

  task automatic test_overrun();
    int w;
    @(negedge clk);
    valid_in = 1'b1;
    pxl_in_1 = $urandom;
    tick();
    nvec++;
    if (err_overrun !== 1'b1 || valid_out_1 !== 1'b0 || pxl_out_1 !== e1) begin
      nerr++;
      $display("FAIL overrun_idle: ovr=%b vout=%b p1=%h want 1 0 %h", err_overrun, valid_out_1, pxl_out_1, e1);
    end
    @(negedge clk);
    valid_in = 1'b0;
    do_start();
    feed(2, NPIX, 1'b0, w);
    drive_cv(OUT_TOTAL, 0);
    nvec++;
    if (err_overrun !== 1'b1) begin nerr++; $display("FAIL overrun_sticky: got %b want 1", err_overrun); end
    check_done_pulse("ovr");
    test_reset(1);
  endtask

  task automatic test_timeout();
    int w, n;
    do_start();
    feed(0, NPIX, 1'b0, w);
    drive_cv(5, 0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    nvec++;
    if (n != TMO || err_timeout !== 1'b1) begin
      nerr++;
      $display("FAIL timeout: done after %0d cycles tmo=%b want %0d 1", n, err_timeout, TMO);
    end
    nvec++;
    if (out_count !== CW'(5)) begin nerr++; $display("FAIL tmo_count: got %0d want 5", out_count); end
    check_done_pulse("tmo");
    nvec++;
    if (err_timeout !== 1'b1) begin nerr++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    test_reset(1);
  endtask

  task automatic test_reset_mid();
    int w;
    do_start();
    feed(0, 20, 1'b0, w);
    test_reset(1);
    test_frame_done();
  endtask

  initial begin
    test_reset(2);
    test_frame_done();
    test_gaps(1);
    test_gaps(2);
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
